reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- Architectural register file for the 32-bit MIPS pipeline; the receiving end of the writeback stage's rfWriteData_p0/rfWriteAddr_p0/rfWriteEn_p0 write port.
- Serves two registered read ports to decode.
- Keeps a per-register busy scoreboard: decode marks destinations pending, writeback clears them.
- Stalls decode on read-after-write hazards and bypasses same-cycle writes to the readers.

Parameters:
DATA_W, 32, register and data width
NUM_REGS, 32, number of architectural registers; register 0 hardwired to zero
ADDR_W, 5, register address width; must equal clog2(NUM_REGS)

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
rfWriteData_p0  input  DATA_W  write data from writeback
rfWriteAddr_p0  input  ADDR_W  write address from writeback
rfWriteEn_p0  input  1  write enable from writeback
wb_done  input  1  writeback done_out; a write happens only when rfWriteEn_p0 && wb_done
rd_valid_in  input  1  decode presents a read/issue request this cycle
rfReadAddr_p0  input  ADDR_W  source register 0 (rs)
rfReadAddr_p1  input  ADDR_W  source register 1 (rt)
rd_dest  input  ADDR_W  destination register of the issuing instruction
rd_dest_en  input  1  the issuing instruction writes rd_dest
rfReadData_p0  output  DATA_W  registered read data, port 0
rfReadData_p1  output  DATA_W  registered read data, port 1
rd_done_out  output  1  read data valid; the done flag passed down the pipe
stall  output  1  combinational; issue blocked this cycle

Behaviour:
- Reset (async, active-high):
  - regs[1..NUM_REGS-1] = 0 and busy[all] = 0.
  - rfReadData_p0 = rfReadData_p1 = 0 and rd_done_out = 0.
  - Reset asserted mid-operation discards pending reads and clears the scoreboard immediately; no write is performed in that cycle.
- Write (wr_fire = rfWriteEn_p0 && wb_done):
  - On the clock edge, regs[rfWriteAddr_p0] = rfWriteData_p0.
  - Address 0 is ignored: regs[0] is never written and busy[0] is never set.
- Source ready:
  - A source is ready if address==0, or busy[addr]==0, or (wr_fire && rfWriteAddr_p0==addr).
  - The last case is the write-through bypass.
- Stall and issue:
  - stall = rd_valid_in && !(ready(p0) && ready(p1)).
  - issue = rd_valid_in && !stall.
- Read latency is 1 cycle. On an issue edge:
  - rfReadData_pN = 0 if addr==0.
  - Else rfReadData_pN = rfWriteData_p0 if wr_fire && rfWriteAddr_p0==addr (write-first bypass).
  - Else rfReadData_pN = regs[addr].
  - rd_done_out = 1.
- When not issuing (idle or stalled):
  - rd_done_out = 0 next cycle.
  - Read data outputs hold their last values.
- Scoreboard:
  - Set busy[rd_dest] on issue && rd_dest_en && rd_dest!=0.
  - Clear busy[rfWriteAddr_p0] on wr_fire.
  - If set and clear hit the same address in one cycle, set wins (a new producer supersedes the completing one).
- Boundary cases:
  - Both ports may read the same register.
  - An instruction may read its own destination: the sources are evaluated before the set takes effect, so no self-stall.
  - A write to a non-busy register is legal and just updates it.
- No internal FSM beyond the busy vector and the output pipeline register; the stall path must not depend on the read data registers.

Optional Feature:
RF_BYPASS_EN
- Defined:
  - Write-through bypass as described.
  - A source written in the same cycle is ready and reads rfWriteData_p0.
- Undefined:
  - No bypass; ready = address==0 || busy[addr]==0.
  - A same-cycle write to a busy source stalls one extra cycle.
  - A same-cycle read of a non-busy register being written returns the old regs[] value.
  - Scoreboard set/clear priority is unchanged.

Test Plan:
- Reset, then issue with p0=5, p1=0 → next cycle rfReadData_p0=0, rfReadData_p1=0, rd_done_out=1; all busy=0.
- wr_fire addr=3 data=0xDEADBEEF; the next cycle reads p0=3 → 0xDEADBEEF. Write addr=0 data=0x1234 → a read of 0 returns 0.
- Issue dest=7 (rd_dest_en=1), next issue reads p1=7 → stall=1 and rd_done_out=0 until the write to 7 with 0x55; in the write cycle (bypass on), stall=0 and next-cycle rfReadData_p1=0x55. With the macro undefined, stall holds one extra cycle.
- Same cycle: issue dest=9 and wr_fire addr=9 → busy[9]=1 afterwards (set wins); a later read of 9 stalls.
- Async reset asserted while busy[4]=1 and rd_done_out=1 → busy cleared, rd_done_out=0 and outputs 0 without waiting for a clock edge.
- Issue reading p0=p1=12 with dest=12 and busy[12]=0 → no stall, both ports return regs[12]; busy[12]=1 afterwards.

Source files
------------

// File: rtl/reg_file_2r1w_if.sv
// Decode/writeback-facing bus of the 2-read/1-write register file.
// The master side is the pipeline (writeback + decode); the slave side is the register file.
interface reg_file_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic [DATA_W-1:0] rfWriteData_p0;
  logic [ADDR_W-1:0] rfWriteAddr_p0;
  logic              rfWriteEn_p0;
  logic              wb_done;
  logic              rd_valid_in;
  logic [ADDR_W-1:0] rfReadAddr_p0;
  logic [ADDR_W-1:0] rfReadAddr_p1;
  logic [ADDR_W-1:0] rd_dest;
  logic              rd_dest_en;
  logic [DATA_W-1:0] rfReadData_p0;
  logic [DATA_W-1:0] rfReadData_p1;
  logic              rd_done_out;
  logic              stall;

  modport master (
    output rfWriteData_p0, rfWriteAddr_p0, rfWriteEn_p0, wb_done,
    output rd_valid_in, rfReadAddr_p0, rfReadAddr_p1, rd_dest, rd_dest_en,
    input  rfReadData_p0, rfReadData_p1, rd_done_out, stall
  );

  modport slave (
    input  rfWriteData_p0, rfWriteAddr_p0, rfWriteEn_p0, wb_done,
    input  rd_valid_in, rfReadAddr_p0, rfReadAddr_p1, rd_dest, rd_dest_en,
    output rfReadData_p0, rfReadData_p1, rd_done_out, stall
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write architectural register file with busy scoreboard and RAW stall.
// Build option RF_BYPASS_EN: a same-cycle writeback both readies and feeds a pending source.
module reg_file_2r1w #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input logic            clk,
  input logic            rst,
  reg_file_2r1w_if.slave rf
);

`ifdef RF_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [DATA_W-1:0]   rdata0_r;
  logic [DATA_W-1:0]   rdata1_r;
  logic [DATA_W-1:0]   rdata0_nxt_s;
  logic [DATA_W-1:0]   rdata1_nxt_s;
  logic                rd_done_r;
  logic                wr_fire_s;
  logic                wr_commit_s;
  logic                hit0_s;
  logic                hit1_s;
  logic                rdy0_s;
  logic                rdy1_s;
  logic                stall_s;
  logic                issue_s;
  logic                set_en_s;

  // Readiness, stall and issue decode; stall depends only on busy state and live inputs
  always_comb begin
    wr_fire_s   = rf.rfWriteEn_p0 && rf.wb_done;
    wr_commit_s = wr_fire_s && (rf.rfWriteAddr_p0 != ZERO_ADDR);
    hit0_s      = wr_fire_s && (rf.rfWriteAddr_p0 == rf.rfReadAddr_p0);
    hit1_s      = wr_fire_s && (rf.rfWriteAddr_p0 == rf.rfReadAddr_p1);
    rdy0_s      = (rf.rfReadAddr_p0 == ZERO_ADDR) || !busy_r[rf.rfReadAddr_p0] || (BYPASS_EN && hit0_s);
    rdy1_s      = (rf.rfReadAddr_p1 == ZERO_ADDR) || !busy_r[rf.rfReadAddr_p1] || (BYPASS_EN && hit1_s);
    stall_s     = rf.rd_valid_in && !(rdy0_s && rdy1_s);
    issue_s     = rf.rd_valid_in && !stall_s;
    set_en_s    = issue_s && rf.rd_dest_en && (rf.rd_dest != ZERO_ADDR);
  end

  // Read muxes: r0 reads as zero, then optional write-first bypass, then the array
  always_comb begin
    rdata0_nxt_s = ZERO_DATA;
    rdata1_nxt_s = ZERO_DATA;
    if (rf.rfReadAddr_p0 == ZERO_ADDR) begin
      rdata0_nxt_s = ZERO_DATA;
    end else if (BYPASS_EN && hit0_s) begin
      rdata0_nxt_s = rf.rfWriteData_p0;
    end else begin
      rdata0_nxt_s = regs_r[rf.rfReadAddr_p0];
    end
    if (rf.rfReadAddr_p1 == ZERO_ADDR) begin
      rdata1_nxt_s = ZERO_DATA;
    end else if (BYPASS_EN && hit1_s) begin
      rdata1_nxt_s = rf.rfWriteData_p0;
    end else begin
      rdata1_nxt_s = regs_r[rf.rfReadAddr_p1];
    end
  end

  // Scoreboard next state: a new producer's set overrides a same-address completion
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_nxt_s[i] = (set_en_s && (rf.rd_dest == ADDR_W'(i)))           ? 1'b1 :
                      (wr_fire_s && (rf.rfWriteAddr_p0 == ADDR_W'(i)))  ? 1'b0 :
                      busy_r[i];
    end
  end

  // Register array; writes to r0 are dropped so it stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= ZERO_DATA;
      end
    end else if (wr_commit_s) begin
      regs_r[rf.rfWriteAddr_p0] <= rf.rfWriteData_p0;
    end
  end

  // Busy scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Output pipeline register: data only moves on issue, done pulses per issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_r  <= ZERO_DATA;
      rdata1_r  <= ZERO_DATA;
      rd_done_r <= 1'b0;
    end else begin
      rd_done_r <= issue_s;
      if (issue_s) begin
        rdata0_r <= rdata0_nxt_s;
        rdata1_r <= rdata1_nxt_s;
      end
    end
  end

  assign rf.rfReadData_p0 = rdata0_r;
  assign rf.rfReadData_p1 = rdata1_r;
  assign rf.rd_done_out   = rd_done_r;
  assign rf.stall         = stall_s;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed plus randomized bench for reg_file_2r1w against an array/flag reference model.
// Honors RF_BYPASS_EN the same way as the design build.
module tb_reg_file_2r1w;
  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_2r1w #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (bus)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] mregs [32];
  bit          mbusy [32];
  logic [31:0] exp_d0;
  logic [31:0] exp_d1;
  bit          last_issue;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mbusy[i];
    return v;
  endfunction

  function automatic bit model_ready(input logic [4:0] a, input bit wf);
    bit r;
    r = (a == 5'd0) || !mbusy[a];
`ifdef RF_BYPASS_EN
    if (wf && bus.rfWriteAddr_p0 == a) r = 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit wf);
    if (a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (wf && bus.rfWriteAddr_p0 == a) return bus.rfWriteData_p0;
`endif
    return mregs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = 32'd0;
      mbusy[i] = 1'b0;
    end
    exp_d0 = 32'd0;
    exp_d1 = 32'd0;
  endtask

  task automatic drive(input bit rv, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] dest, input bit den,
                       input bit we, input bit wbd, input logic [4:0] wa, input logic [31:0] wd);
    bus.rd_valid_in    = rv;
    bus.rfReadAddr_p0  = a0;
    bus.rfReadAddr_p1  = a1;
    bus.rd_dest        = dest;
    bus.rd_dest_en     = den;
    bus.rfWriteEn_p0   = we;
    bus.wb_done        = wbd;
    bus.rfWriteAddr_p0 = wa;
    bus.rfWriteData_p0 = wd;
  endtask

  // One clock: predict and check stall, advance the model, then check the registered outputs
  task automatic step(input string tag);
    bit wf, exp_stall, issue;
    #1;
    wf        = bus.rfWriteEn_p0 && bus.wb_done;
    exp_stall = bus.rd_valid_in &&
                !(model_ready(bus.rfReadAddr_p0, wf) && model_ready(bus.rfReadAddr_p1, wf));
    issue     = bus.rd_valid_in && !exp_stall;
    check({tag, "/stall"}, {31'd0, bus.stall}, {31'd0, exp_stall});
    if (issue) begin
      exp_d0 = model_read(bus.rfReadAddr_p0, wf);
      exp_d1 = model_read(bus.rfReadAddr_p1, wf);
    end
    if (wf && bus.rfWriteAddr_p0 != 5'd0) mregs[bus.rfWriteAddr_p0] = bus.rfWriteData_p0;
    if (wf) mbusy[bus.rfWriteAddr_p0] = 1'b0;
    if (issue && bus.rd_dest_en && bus.rd_dest != 5'd0) mbusy[bus.rd_dest] = 1'b1;
    last_issue = issue;
    @(posedge clk);
    #1;
    check({tag, "/done"}, {31'd0, bus.rd_done_out}, {31'd0, issue});
    check({tag, "/d0"}, bus.rfReadData_p0, exp_d0);
    check({tag, "/d1"}, bus.rfReadData_p1, exp_d1);
    check({tag, "/busy"}, dut.busy_r, busy_vec());
  endtask

  initial begin
    model_reset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst/done", {31'd0, bus.rd_done_out}, 32'd0);
    check("rst/d0", bus.rfReadData_p0, 32'd0);
    check("rst/d1", bus.rfReadData_p1, 32'd0);
    check("rst/busy", dut.busy_r, 32'd0);
    rst = 1'b0;

    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step("first_read");

    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
    step("wr3");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 32'hBAD0BAD0);
    step("wr5_no_done");
    drive(1'b1, 5'd3, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h00001234);
    step("rd3_wr0");
    drive(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step("rd0");

    // RAW on r7: producer issues, consumer stalls until writeback
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step("dest7");
    drive(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step("raw_stall_a");
    step("raw_stall_b");
    drive(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h00000055);
    step("raw_wb");
    drive(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    if (!last_issue) step("raw_retry");
    check("raw/d1_final", bus.rfReadData_p1, 32'h00000055);

    // Set and clear of r9 in one cycle: set must win
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 32'h00000099);
    step("setwins");
    drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step("setwins_probe");

    // Async reset while r4 busy and done high
    drive(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step("pre_arst");
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst/done", {31'd0, bus.rd_done_out}, 32'd0);
    check("arst/d0", bus.rfReadData_p0, 32'd0);
    check("arst/d1", bus.rfReadData_p1, 32'd0);
    check("arst/busy", dut.busy_r, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Self-read of destination with both ports on the same register
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd12, 32'hC0FFEE12);
    step("wr12");
    drive(1'b1, 5'd12, 5'd12, 5'd12, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    step("self12");
    check("self12/busy12", {31'd0, dut.busy_r[12]}, 32'd1);

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 15)), $urandom());
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
